// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth signed multiplier: one recoding step per clock, WIDTH steps per product.
// Optional BOOTH_DONE_EN adds a one-cycle `done` pulse coinciding with `busy` falling.
module booth_multiplier #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   AB,
    output logic                 busy
`ifdef BOOTH_DONE_EN
    ,
    output logic                 done
`endif
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH:0]   m;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] q;
    logic             q_1;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   nacc;
    logic [WIDTH-1:0] nq;
    logic             nq_1;

    // One Booth step: add/subtract M on {Q[0],Q_1}, then arithmetic shift {ACC,Q,Q_1} right.
    always_comb begin
        sum = acc;
        case ({q[0], q_1})
            2'b01:   sum = acc + m;
            2'b10:   sum = acc - m;
            default: sum = acc;
        endcase
        nacc = {sum[WIDTH], sum[WIDTH:1]};
        nq   = {sum[0], q[WIDTH-1:1]};
        nq_1 = q[0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            m     <= '0;
            acc   <= '0;
            q     <= '0;
            q_1   <= 1'b0;
            cnt   <= '0;
            AB    <= '0;
            busy  <= 1'b0;
`ifdef BOOTH_DONE_EN
            done  <= 1'b0;
`endif
        end else begin
`ifdef BOOTH_DONE_EN
            done <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        m     <= {A[WIDTH-1], A};
                        acc   <= '0;
                        q     <= B;
                        q_1   <= 1'b0;
                        cnt   <= CW'(WIDTH);
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= nacc;
                    q   <= nq;
                    q_1 <= nq_1;
                    cnt <= cnt - CW'(1);
                    // Last step: product is the low 2*WIDTH bits of the shifted {ACC,Q}.
                    if (cnt == CW'(1)) begin
                        AB    <= {nacc[WIDTH-1:0], nq};
                        busy  <= 1'b0;
                        state <= IDLE;
`ifdef BOOTH_DONE_EN
                        done  <= 1'b1;
`endif
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_multiplier.sv
// Directed self-checking bench for booth_multiplier (WIDTH=8), including reset abort,
// busy-time operand/start toggling, back-to-back throughput and a short random sweep.
module tb_booth_multiplier;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [15:0] AB;
    logic        busy;
`ifdef BOOTH_DONE_EN
    logic        done;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int last_exp = 0;

    booth_multiplier #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .AB    (AB),
        .busy  (busy)
`ifdef BOOTH_DONE_EN
        ,
        .done  (done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one operation, holds start for `hold` cycles, checks latency, hold and result.
    task automatic do_mult(input logic [7:0] a, input logic [7:0] b, input int exp, input int hold);
        int n;
        A = a;
        B = b;
        start = 1'b1;
        step();
        check("busy_rise", int'(busy), 1);
        n = 0;
        while (busy && n < 20) begin
            if (n >= hold - 1) start = 1'b0;
            if (n == 4) check("ab_hold", int'($signed(AB)), last_exp);
            step();
            n++;
        end
        check("latency", n, 8);
        check("product", int'($signed(AB)), exp);
`ifdef BOOTH_DONE_EN
        check("done_pulse", int'(done), 1);
        step();
        check("done_clear", int'(done), 0);
`endif
        last_exp = exp;
    endtask

    initial begin
        int n;
        logic [7:0] ra;
        logic [7:0] rb;

        rst_n = 1'b0;
        start = 1'b0;
        A = 8'd0;
        B = 8'd0;
        step();
        step();
        check("rst_ab", int'($signed(AB)), 0);
        check("rst_busy", int'(busy), 0);
`ifdef BOOTH_DONE_EN
        check("rst_done", int'(done), 0);
`endif
        rst_n = 1'b1;
        step();

        do_mult(8'd3, 8'd17, 51, 5);
        do_mult(8'd7, 8'd7, 49, 5);
        do_mult(8'(-5), 8'd12, -60, 1);
        do_mult(8'h80, 8'h80, 16384, 1);
        do_mult(8'h80, 8'd127, -16256, 1);
        do_mult(8'd0, 8'hFF, 0, 1);

        // Operands and start toggle while busy: captured pair must win, no mid-run restart.
        A = 8'd5;
        B = 8'(-3);
        start = 1'b1;
        step();
        check("tog_busy", int'(busy), 1);
        n = 0;
        while (busy && n < 20) begin
            A = 8'($urandom);
            B = 8'($urandom);
            start = (n < 6) ? ~start : 1'b0;
            step();
            n++;
        end
        start = 1'b0;
        check("tog_latency", n, 8);
        check("tog_product", int'($signed(AB)), -15);
        last_exp = -15;
        step();

        // Reset three cycles into an operation aborts it.
        A = 8'd9;
        B = 8'd9;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("abort_ab", int'($signed(AB)), 0);
        check("abort_busy", int'(busy), 0);
`ifdef BOOTH_DONE_EN
        check("abort_done", int'(done), 0);
`endif
        last_exp = 0;
        step();
        do_mult(8'd6, 8'(-7), -42, 1);

        // Start held continuously: one idle cycle, then restart with the current operands.
        A = 8'd2;
        B = 8'd3;
        start = 1'b1;
        step();
        A = 8'(-4);
        B = 8'(-4);
        n = 0;
        while (busy && n < 20) begin
            step();
            n++;
        end
        check("b2b_latency1", n, 8);
        check("b2b_product1", int'($signed(AB)), 6);
        step();
        check("b2b_restart", int'(busy), 1);
        start = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            step();
            n++;
        end
        check("b2b_latency2", n, 8);
        check("b2b_product2", int'($signed(AB)), 16);
        last_exp = 16;
        step();

        // Short random sweep against a signed reference.
        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            do_mult(ra, rb, int'($signed(ra)) * int'($signed(rb)), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
